// File: rtl/camera_capture_ctrl_if.sv
// Bus bundle for the camera capture sequencer: Avalon-MM register port,
// synchronized camera pixel stream and the linear frame-buffer write port.
interface camera_capture_ctrl_if #(
    parameter int ADDR_W = 17
);
    logic [1:0]        address;
    logic              write;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              irq;

    logic              cam_vsync;
    logic              cam_href;
    logic              cam_pvalid;
    logic [11:0]       cam_data;

    logic              fb_wr_en;
    logic [ADDR_W-1:0] fb_wr_addr;
    logic [11:0]       fb_wr_data;

    modport slave (
        input  address, write, writedata,
        input  cam_vsync, cam_href, cam_pvalid, cam_data,
        output readdata, irq,
        output fb_wr_en, fb_wr_addr, fb_wr_data
    );

    modport master (
        output address, write, writedata,
        output cam_vsync, cam_href, cam_pvalid, cam_data,
        input  readdata, irq,
        input  fb_wr_en, fb_wr_addr, fb_wr_data
    );
endinterface

// File: rtl/camera_capture_ctrl.sv
// Frame-capture sequencer: arms on a CPU command, aligns to vsync, streams
// valid pixels to a linear frame buffer and reports status over Avalon-MM.
module camera_capture_ctrl #(
    parameter int ADDR_W  = 17,
    parameter int MAX_PIX = 76800
) (
    input  logic                 clk,
    input  logic                 reset_n,
    camera_capture_ctrl_if.slave bus
);
    localparam int               CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0] MAX_PIX_C = CNT_W'(MAX_PIX);
    localparam logic [15:0]      LINE_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        SYNC    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic              cont_reg, cont_next;
    logic              irq_en_reg, irq_en_next;
    logic              done_reg, done_next;
    logic              ovf_reg, ovf_next;
    logic [CNT_W-1:0]  pix_cnt_reg, pix_cnt_next;
    logic [15:0]       line_cnt_reg, line_cnt_next;
    logic [CNT_W-1:0]  pixcnt_reg, pixcnt_next;
    logic [15:0]       linecnt_reg, linecnt_next;
    logic              vs_q_reg, hr_q_reg;
    logic [31:0]       readdata_reg, readdata_next;
    logic              irq_reg;
    logic              fb_wr_en_reg, fb_wr_en_next;
    logic [ADDR_W-1:0] fb_wr_addr_reg, fb_wr_addr_next;
    logic [11:0]       fb_wr_data_reg, fb_wr_data_next;

    logic ctrl_wr, status_wr, start_cmd, abort_cmd;
    logic vs_rise, vs_fall, hr_fall, pix_sample, busy;
    logic unused_writedata;

    assign ctrl_wr    = bus.write && (bus.address == 2'd0);
    assign status_wr  = bus.write && (bus.address == 2'd1);
    // ABORT dominates START when both arrive in one write.
    assign abort_cmd  = ctrl_wr && bus.writedata[2];
    assign start_cmd  = ctrl_wr && bus.writedata[0] && !bus.writedata[2];

    assign vs_rise    = bus.cam_vsync && !vs_q_reg;
    assign vs_fall    = !bus.cam_vsync && vs_q_reg;
    assign hr_fall    = !bus.cam_href && hr_q_reg;
    assign pix_sample = bus.cam_href && bus.cam_pvalid && !bus.cam_vsync;
    assign busy       = (state_reg != IDLE);

    assign unused_writedata = ^bus.writedata[31:4];

    always_comb begin
        state_next      = state_reg;
        cont_next       = cont_reg;
        irq_en_next     = irq_en_reg;
        done_next       = done_reg;
        ovf_next        = ovf_reg;
        pix_cnt_next    = pix_cnt_reg;
        line_cnt_next   = line_cnt_reg;
        pixcnt_next     = pixcnt_reg;
        linecnt_next    = linecnt_reg;
        fb_wr_en_next   = 1'b0;
        fb_wr_addr_next = fb_wr_addr_reg;
        fb_wr_data_next = fb_wr_data_reg;

        if (ctrl_wr) begin
            cont_next   = bus.writedata[1];
            irq_en_next = bus.writedata[3];
        end

        // W1C is applied before any set below so a same-cycle set wins.
        if (status_wr) begin
            if (bus.writedata[1]) done_next = 1'b0;
            if (bus.writedata[2]) ovf_next  = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (start_cmd) begin
                    state_next = ARMED;
                    done_next  = 1'b0;
                    ovf_next   = 1'b0;
                end
            end
            ARMED: begin
                // Waiting for a fresh frame start avoids a partial frame.
                if (vs_rise) state_next = SYNC;
            end
            SYNC: begin
                if (vs_fall) begin
                    state_next    = CAPTURE;
                    pix_cnt_next  = '0;
                    line_cnt_next = '0;
                end
            end
            CAPTURE: begin
                if (pix_sample) begin
                    if (pix_cnt_reg < MAX_PIX_C) begin
                        fb_wr_en_next   = 1'b1;
                        fb_wr_addr_next = pix_cnt_reg[ADDR_W-1:0];
                        fb_wr_data_next = bus.cam_data;
                        pix_cnt_next    = pix_cnt_reg + 1'b1;
                    end else begin
                        ovf_next = 1'b1;
                    end
                end
                if (hr_fall && (line_cnt_reg != LINE_MAX)) begin
                    line_cnt_next = line_cnt_reg + 1'b1;
                end
                if (vs_rise && !abort_cmd) begin
                    pixcnt_next  = pix_cnt_next;
                    linecnt_next = line_cnt_next;
                    done_next    = 1'b1;
                    // In continuous mode the next frame is already in blanking.
                    state_next   = cont_reg ? SYNC : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (abort_cmd) state_next = IDLE;
    end

    always_comb begin
        readdata_next = 32'd0;
        case (bus.address)
            2'd0: readdata_next = {28'd0, irq_en_reg, 1'b0, cont_reg, 1'b0};
            2'd1: readdata_next = {26'd0, 2'(state_reg), 1'b0, ovf_reg, done_reg, busy};
            2'd2: readdata_next = 32'(pixcnt_reg);
            2'd3: readdata_next = {16'd0, linecnt_reg};
            default: readdata_next = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            cont_reg       <= 1'b0;
            irq_en_reg     <= 1'b0;
            done_reg       <= 1'b0;
            ovf_reg        <= 1'b0;
            pix_cnt_reg    <= '0;
            line_cnt_reg   <= '0;
            pixcnt_reg     <= '0;
            linecnt_reg    <= '0;
            vs_q_reg       <= 1'b0;
            hr_q_reg       <= 1'b0;
            readdata_reg   <= 32'd0;
            irq_reg        <= 1'b0;
            fb_wr_en_reg   <= 1'b0;
            fb_wr_addr_reg <= '0;
            fb_wr_data_reg <= '0;
        end else begin
            state_reg      <= state_next;
            cont_reg       <= cont_next;
            irq_en_reg     <= irq_en_next;
            done_reg       <= done_next;
            ovf_reg        <= ovf_next;
            pix_cnt_reg    <= pix_cnt_next;
            line_cnt_reg   <= line_cnt_next;
            pixcnt_reg     <= pixcnt_next;
            linecnt_reg    <= linecnt_next;
            vs_q_reg       <= bus.cam_vsync;
            hr_q_reg       <= bus.cam_href;
            readdata_reg   <= readdata_next;
            irq_reg        <= done_reg & irq_en_reg;
            fb_wr_en_reg   <= fb_wr_en_next;
            fb_wr_addr_reg <= fb_wr_addr_next;
            fb_wr_data_reg <= fb_wr_data_next;
        end
    end

    assign bus.readdata   = readdata_reg;
    assign bus.irq        = irq_reg;
    assign bus.fb_wr_en   = fb_wr_en_reg;
    assign bus.fb_wr_addr = fb_wr_addr_reg;
    assign bus.fb_wr_data = fb_wr_data_reg;
endmodule
